mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified memory bus between the core's instruction-fetch (imem) and data (dmem) ports. Sits between `core` and the memory subsystem. Accepts each port's request, holds it in a pending register, serializes pending requests onto the bus with fixed priority, and returns read data to the originating port. Stalls the pipeline through the existing `imem_wait`/`dmem_wait` inputs of the core.

## Interface
- `DMEM_PRIORITY`, 1, 1: dmem wins when both ports are pending and the bus is free; 0: imem wins.
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `imem_address`  input  32  fetch address (word aligned)
- `imem_enable`  input  1  fetch request
- `imem_data`  output  32  registered fetch data
- `imem_wait`  output  1  fetch pending
- `dmem_address`  input  32  data address
- `dmem_enable`  input  1  qualifies `dmem_read_enable`/`dmem_write_enable`
- `dmem_write_data`  input  32  store data
- `dmem_write_enable`  input  1  store request
- `dmem_write_mode`  input  3  store width code (passed through)
- `dmem_read_enable`  input  1  load request
- `dmem_read_mode`  input  3  load width code (passed through)
- `dmem_read_data`  output  32  registered load data
- `dmem_wait`  output  1  data access pending
- `bus_request`  output  1  transaction valid
- `bus_address`  output  32  transaction address
- `bus_write`  output  1  1 = store, 0 = load/fetch
- `bus_write_data`  output  32  store data
- `bus_mode`  output  3  width code; fetch uses 3'b010
- `bus_ready`  input  1  transaction completes this cycle; read data valid
- `bus_read_data`  input  32  read data, sampled when `bus_ready`=1
- `overrun`  output  1  sticky: a new request arrived while the same port was pending

## Operation
- Acceptance:
  - imem request: `imem_enable`=1 and the imem side is not pending.
  - dmem request: `dmem_enable`=1, (`dmem_read_enable` or `dmem_write_enable`)=1, and the dmem side is not pending.
  - `dmem_enable` alone, with neither read nor write enable, is not a request.
  - On acceptance, address, data, mode and write flag are captured and the pending bit is set.
  - Both ports may be accepted in the same cycle.
- Write priority: if `dmem_write_enable` and `dmem_read_enable` are both 1, the request is a write.
- Overrun: a request on a port that is already pending is dropped and `overrun` is set. Only reset clears `overrun`.
- FSM states: ARB_IDLE, ARB_IMEM, ARB_DMEM.
  - IDLE -> IMEM or DMEM on the edge where a pending bit exists or is being set. Priority follows `DMEM_PRIORITY`.
  - IMEM/DMEM -> on a `bus_ready` edge, clear that port's pending bit. Go directly to the other state if that port is pending (or is being accepted on this edge); otherwise go to IDLE.
- `bus_request`=1 exactly in IMEM/DMEM. Bus outputs come from the served port's capture registers and are stable while `bus_request`=1.
- `bus_ready` while IDLE is ignored.
- Completion:
  - Fetch: `imem_data` <= `bus_read_data` on the bus_ready edge.
  - Load: `dmem_read_data` <= `bus_read_data` on the bus_ready edge.
  - Store: `dmem_read_data` is unchanged.
  - Return data holds until the next completion on that port.
- `imem_wait` = imem pending bit; `dmem_wait` = dmem pending bit. Both are registered, with no combinational path from inputs.

## Timing
- Request in cycle 0 -> pending bit set and `bus_request`=1 in cycle 1 (if the bus is free).
- Zero-wait memory (`bus_ready`=1 in cycle 1) -> data valid and wait low in cycle 2.
- Each extra bus wait cycle adds one cycle of latency.
- Both ports requesting in cycle 0, `DMEM_PRIORITY`=1, zero-wait memory: dmem served in cycle 1, imem in cycle 2, no idle cycle between them.
- Reset values:
  - `imem_data`, `dmem_read_data`, `bus_address`, `bus_write_data` = 0.
  - `bus_mode` = 0.
  - `bus_request`, `bus_write`, `imem_wait`, `dmem_wait`, `overrun` = 0.
  - FSM = ARB_IDLE; both pending bits = 0.
- Reset mid-transaction: `bus_request` drops immediately (asynchronous) and the transaction is abandoned. The memory side must tolerate an abandoned transaction.

## Structure
- Add `arb_state_t` (ARB_IDLE, ARB_IMEM, ARB_DMEM) and the constant `MODE_WORD` = 3'b010 to the shared `types.sv` package.
- Sub-module `arb_request_latch`, instantiated once per port:
  - Holds the pending bit, address, data, mode and write flag.
  - Has `accept` and `complete` inputs.
  - Flags overrun when a request arrives while pending.
- The top level holds the FSM, the bus output mux and the return-data registers.

## Test plan
- Single fetch, zero-wait: `imem_address`=0x10 in cycle 0 with `bus_read_data`=0x00000013 -> `bus_request`=1 and `bus_address`=0x10 in cycle 1; `imem_data`=0x13 and `imem_wait`=0 in cycle 2.
- Simultaneous fetch 0x20 and load 0x100 with `DMEM_PRIORITY`=1 -> bus serves 0x100 in cycle 1 and 0x20 in cycle 2; `dmem_wait` falls in cycle 2, `imem_wait` in cycle 3.
- Store 0xDEADBEEF to 0x200, mode 3'b000, with bus_ready delayed 3 cycles -> bus outputs stable for 3 cycles with `bus_write`=1; `dmem_read_data` unchanged.
- `dmem_enable`=1 with both read and write enables 0 for 10 cycles -> `bus_request` stays 0 and `dmem_wait` stays 0.
- Second fetch while a fetch is pending -> `overrun`=1 and stays 1; the original transaction completes normally.
- `reset` asserted with `bus_request`=1 -> all outputs 0 in the same cycle; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the imem/dmem bus arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM: idle, or serving one of the two ports on the bus.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IMEM = 2'd1,
        ARB_DMEM = 2'd2
    } arb_state_t;

    // Width code used for every instruction fetch.
    localparam logic [2:0] MODE_WORD = 3'b010;

    // One captured bus transaction.
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  mode;
        logic        write;
    } bus_req_t;

endpackage

// File: rtl/mem_arbiter_request_latch.sv
// Per-port pending-request register: captures one transaction on accept and
// holds it until the bus reports completion. A request seen while already
// pending is dropped and recorded in a sticky overrun flag.
module arb_request_latch
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     request,
    input  logic     accept,
    input  logic     complete,
    input  bus_req_t req_in,
    output logic     pending,
    output bus_req_t req_q,
    output logic     overrun
);

    // Capture on accept, clear on completion, latch overrun until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            req_q   <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
                req_q   <= req_in;
            end else if (complete) begin
                pending <= 1'b0;
            end
            if (request && pending) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the core's fetch (imem) and data
// (dmem) ports. Each port's request is held in a pending latch; the FSM puts
// one pending request at a time onto the bus with fixed priority.
//
// Bus handshake: bus_request is the valid. While it is high the address,
// write flag, data and mode are stable. The transaction completes on the
// rising edge where bus_ready is high, and bus_read_data is sampled on that
// same edge. bus_ready while bus_request is low is ignored. An asynchronous
// reset may drop bus_request mid-transaction; the memory side abandons it.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit DMEM_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_address,
    input  logic        imem_enable,
    output logic [31:0] imem_data,
    output logic        imem_wait,
    input  logic [31:0] dmem_address,
    input  logic        dmem_enable,
    input  logic [31:0] dmem_write_data,
    input  logic        dmem_write_enable,
    input  logic [2:0]  dmem_write_mode,
    input  logic        dmem_read_enable,
    input  logic [2:0]  dmem_read_mode,
    output logic [31:0] dmem_read_data,
    output logic        dmem_wait,
    output logic        bus_request,
    output logic [31:0] bus_address,
    output logic        bus_write,
    output logic [31:0] bus_write_data,
    output logic [2:0]  bus_mode,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data,
    output logic        overrun,
    output arb_state_t  state_dbg
);

    arb_state_t state, state_next;

    logic     i_req, i_acc, i_pend, i_done, i_ovr;
    logic     d_req, d_acc, d_pend, d_done, d_ovr;
    bus_req_t i_in, d_in, i_q, d_q, served;

    // Request qualification; a write wins when both enables are set.
    assign i_req = imem_enable;
    assign d_req = dmem_enable && (dmem_read_enable || dmem_write_enable);
    assign i_acc = i_req && !i_pend;
    assign d_acc = d_req && !d_pend;

    assign i_in = '{address: imem_address, data: 32'h0, mode: MODE_WORD, write: 1'b0};
    assign d_in = '{address: dmem_address,
                    data:    dmem_write_enable ? dmem_write_data : 32'h0,
                    mode:    dmem_write_enable ? dmem_write_mode : dmem_read_mode,
                    write:   dmem_write_enable};

    assign i_done = (state == ARB_IMEM) && bus_ready;
    assign d_done = (state == ARB_DMEM) && bus_ready;

    arb_request_latch u_imem_latch (
        .clk      (clk),
        .reset    (reset),
        .request  (i_req),
        .accept   (i_acc),
        .complete (i_done),
        .req_in   (i_in),
        .pending  (i_pend),
        .req_q    (i_q),
        .overrun  (i_ovr)
    );

    arb_request_latch u_dmem_latch (
        .clk      (clk),
        .reset    (reset),
        .request  (d_req),
        .accept   (d_acc),
        .complete (d_done),
        .req_in   (d_in),
        .pending  (d_pend),
        .req_q    (d_q),
        .overrun  (d_ovr)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start on a pending or newly accepted request, and hand the
    // bus straight to the other port on completion when it has work.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (DMEM_PRIORITY) begin
                    if (d_pend || d_acc)      state_next = ARB_DMEM;
                    else if (i_pend || i_acc) state_next = ARB_IMEM;
                end else begin
                    if (i_pend || i_acc)      state_next = ARB_IMEM;
                    else if (d_pend || d_acc) state_next = ARB_DMEM;
                end
            end
            ARB_IMEM: begin
                if (bus_ready) state_next = (d_pend || d_acc) ? ARB_DMEM : ARB_IDLE;
            end
            ARB_DMEM: begin
                if (bus_ready) state_next = (i_pend || i_acc) ? ARB_IMEM : ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Bus outputs: the served port's captured transaction, zero when idle.
    always_comb begin
        served = '0;
        case (state)
            ARB_IMEM: served = i_q;
            ARB_DMEM: served = d_q;
            default:  served = '0;
        endcase
        bus_request    = (state != ARB_IDLE);
        bus_address    = served.address;
        bus_write      = served.write;
        bus_write_data = served.data;
        bus_mode       = served.mode;
    end

    // Return data: fetches and loads capture read data on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_data      <= 32'h0;
            dmem_read_data <= 32'h0;
        end else begin
            if (i_done) imem_data <= bus_read_data;
            if (d_done && !d_q.write) dmem_read_data <= bus_read_data;
        end
    end

    assign imem_wait = i_pend;
    assign dmem_wait = d_pend;
    assign overrun   = i_ovr || d_ovr;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (DMEM_PRIORITY = 1). Each table row gives
// the inputs driven during one cycle and the outputs expected in that same
// cycle (outputs only reflect earlier edges).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_address, dmem_address, dmem_write_data, bus_read_data;
    logic        imem_enable, dmem_enable, dmem_write_enable, dmem_read_enable, bus_ready;
    logic [2:0]  dmem_write_mode, dmem_read_mode;
    logic [31:0] imem_data, dmem_read_data, bus_address, bus_write_data;
    logic        imem_wait, dmem_wait, bus_request, bus_write, overrun;
    logic [2:0]  bus_mode;
    arb_state_t  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_arbiter #(.DMEM_PRIORITY(1'b1)) dut (
        .clk(clk), .reset(reset),
        .imem_address(imem_address), .imem_enable(imem_enable),
        .imem_data(imem_data), .imem_wait(imem_wait),
        .dmem_address(dmem_address), .dmem_enable(dmem_enable),
        .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
        .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
        .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data),
        .dmem_wait(dmem_wait), .bus_request(bus_request), .bus_address(bus_address),
        .bus_write(bus_write), .bus_write_data(bus_write_data), .bus_mode(bus_mode),
        .bus_ready(bus_ready), .bus_read_data(bus_read_data), .overrun(overrun),
        .state_dbg(state_dbg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    typedef struct {
        logic        ie;  logic [31:0] ia;
        logic        de, dr, dw;
        logic [31:0] da, wd;
        logic [2:0]  wm, rm;
        logic        rdy; logic [31:0] rd;
        logic        e_req; logic [31:0] e_addr; logic e_wr; logic [31:0] e_wd;
        logic [2:0]  e_mode; logic e_iw, e_dw;
        logic [31:0] e_idata, e_ddata; logic e_ovr;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic ie, input logic [31:0] ia,
        input logic de, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] wd,
        input logic [2:0] wm, input logic [2:0] rm,
        input logic rdy, input logic [31:0] rd,
        input logic e_req, input logic [31:0] e_addr, input logic e_wr,
        input logic [31:0] e_wd, input logic [2:0] e_mode,
        input logic e_iw, input logic e_dw,
        input logic [31:0] e_idata, input logic [31:0] e_ddata, input logic e_ovr);
        vec_t v;
        v.ie = ie; v.ia = ia; v.de = de; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
        v.wm = wm; v.rm = rm; v.rdy = rdy; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_wr = e_wr; v.e_wd = e_wd;
        v.e_mode = e_mode; v.e_iw = e_iw; v.e_dw = e_dw;
        v.e_idata = e_idata; v.e_ddata = e_ddata; v.e_ovr = e_ovr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        imem_enable = 0; imem_address = 0;
        dmem_enable = 0; dmem_read_enable = 0; dmem_write_enable = 0;
        dmem_address = 0; dmem_write_data = 0; dmem_write_mode = 0; dmem_read_mode = 0;
        bus_ready = 0; bus_read_data = 0;
    endtask

    task automatic apply_row(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        imem_enable = v.ie; imem_address = v.ia;
        dmem_enable = v.de; dmem_read_enable = v.dr; dmem_write_enable = v.dw;
        dmem_address = v.da; dmem_write_data = v.wd;
        dmem_write_mode = v.wm; dmem_read_mode = v.rm;
        bus_ready = v.rdy; bus_read_data = v.rd;
        #1;
        check($sformatf("row%0d bus_request", i), {31'h0, bus_request}, {31'h0, v.e_req});
        check($sformatf("row%0d bus_address", i), bus_address, v.e_addr);
        check($sformatf("row%0d bus_write", i), {31'h0, bus_write}, {31'h0, v.e_wr});
        check($sformatf("row%0d bus_write_data", i), bus_write_data, v.e_wd);
        check($sformatf("row%0d bus_mode", i), {29'h0, bus_mode}, {29'h0, v.e_mode});
        check($sformatf("row%0d imem_wait", i), {31'h0, imem_wait}, {31'h0, v.e_iw});
        check($sformatf("row%0d dmem_wait", i), {31'h0, dmem_wait}, {31'h0, v.e_dw});
        check($sformatf("row%0d imem_data", i), imem_data, v.e_idata);
        check($sformatf("row%0d dmem_read_data", i), dmem_read_data, v.e_ddata);
        check($sformatf("row%0d overrun", i), {31'h0, overrun}, {31'h0, v.e_ovr});
    endtask

    initial begin
        //            ie ia        de dr dw da        wd            wm      rm      rdy rd             req addr     wr wd            mode    iw dw idata          ddata          ovr
        // reset state
        vecs[0]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 0,             0,             0);
        // single fetch, zero wait
        vecs[1]  = mk(1, 'h10,     0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 'h13,          0, 0,        0, 0,            3'b000, 0, 0, 0,             0,             0);
        vecs[2]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'h13,          1, 'h10,     0, 0,            3'b010, 1, 0, 0,             0,             0);
        vecs[3]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h13,          0,             0);
        // simultaneous fetch + load, dmem first, no idle gap
        vecs[4]  = mk(1, 'h20,     1, 1, 0, 'h100,    0,            3'b000, 3'b010, 0, 'hAAAA5555,    0, 0,        0, 0,            3'b000, 0, 0, 'h13,          0,             0);
        vecs[5]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'hAAAA5555,    1, 'h100,    0, 0,            3'b010, 1, 1, 'h13,          0,             0);
        vecs[6]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'h12345678,    1, 'h20,     0, 0,            3'b010, 1, 0, 'h13,          'hAAAA5555,    0);
        vecs[7]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h12345678,    'hAAAA5555,    0);
        // store with three-cycle bus wait; load data untouched
        vecs[8]  = mk(0, 0,        1, 0, 1, 'h200,    'hDEADBEEF,   3'b000, 3'b111, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h12345678,    'hAAAA5555,    0);
        vecs[9]  = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             1, 'h200,    1, 'hDEADBEEF,   3'b000, 0, 1, 'h12345678,    'hAAAA5555,    0);
        vecs[10] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             1, 'h200,    1, 'hDEADBEEF,   3'b000, 0, 1, 'h12345678,    'hAAAA5555,    0);
        vecs[11] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'hFFFFFFFF,    1, 'h200,    1, 'hDEADBEEF,   3'b000, 0, 1, 'h12345678,    'hAAAA5555,    0);
        vecs[12] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h12345678,    'hAAAA5555,    0);
        // read+write enables together: treated as a store with write mode
        vecs[13] = mk(0, 0,        1, 1, 1, 'h300,    'h11,         3'b001, 3'b100, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h12345678,    'hAAAA5555,    0);
        vecs[14] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'h5A,          1, 'h300,    1, 'h11,         3'b001, 0, 1, 'h12345678,    'hAAAA5555,    0);
        // load accepted on the fetch completion edge: direct IMEM -> DMEM
        vecs[15] = mk(1, 'h50,     0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h12345678,    'hAAAA5555,    0);
        vecs[16] = mk(0, 0,        1, 1, 0, 'h400,    0,            3'b000, 3'b101, 1, 'h99,          1, 'h50,     0, 0,            3'b010, 1, 0, 'h12345678,    'hAAAA5555,    0);
        vecs[17] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'h66,          1, 'h400,    0, 0,            3'b101, 0, 1, 'h99,          'hAAAA5555,    0);
        // second fetch while pending: dropped, overrun sticky
        vecs[18] = mk(1, 'h40,     0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h99,          'h66,          0);
        vecs[19] = mk(1, 'h44,     0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             1, 'h40,     0, 0,            3'b010, 1, 0, 'h99,          'h66,          0);
        vecs[20] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 1, 'h77,          1, 'h40,     0, 0,            3'b010, 1, 0, 'h99,          'h66,          1);
        vecs[21] = mk(0, 0,        0, 0, 0, 0,        0,            3'b000, 3'b000, 0, 0,             0, 0,        0, 0,            3'b000, 0, 0, 'h77,          'h66,          1);
    end

    initial begin
        // clock/reset
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) apply_row(i);

        // dmem_enable alone for 10 cycles, bus_ready ignored while idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive_idle();
            dmem_enable = 1; bus_ready = 1; bus_read_data = 32'hBAD;
            #1;
            check($sformatf("en_only%0d bus_request", c), {31'h0, bus_request}, 32'h0);
            check($sformatf("en_only%0d dmem_wait", c), {31'h0, dmem_wait}, 32'h0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("en_only imem_data", imem_data, 32'h77);
        check("en_only dmem_read_data", dmem_read_data, 32'h66);
        check("en_only overrun", {31'h0, overrun}, 32'h1);

        // reset mid-transaction
        @(negedge clk);
        imem_enable = 1; imem_address = 32'h60;
        @(negedge clk);
        imem_enable = 0;
        #1;
        check("pre_reset bus_request", {31'h0, bus_request}, 32'h1);
        check("pre_reset bus_address", bus_address, 32'h60);
        #2 reset = 1'b1;
        #1;
        check("rst bus_request", {31'h0, bus_request}, 32'h0);
        check("rst bus_address", bus_address, 32'h0);
        check("rst bus_mode", {29'h0, bus_mode}, 32'h0);
        check("rst imem_wait", {31'h0, imem_wait}, 32'h0);
        check("rst overrun", {31'h0, overrun}, 32'h0);
        check("rst imem_data", imem_data, 32'h0);
        check("rst dmem_read_data", dmem_read_data, 32'h0);
        check("rst state", {30'h0, state_dbg}, {30'h0, ARB_IDLE});
        @(negedge clk);
        reset = 1'b0;

        // fetches after reset, expected data through the scoreboard queue
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'h70 + 32'(k * 4);
            d = 32'hC0DE0000 | a;
            exp_q.push_back(d);
            @(negedge clk);
            imem_enable = 1; imem_address = a;
            @(negedge clk);
            imem_enable = 0; bus_ready = 1; bus_read_data = d;
            #1;
            check($sformatf("post_rst%0d bus_address", k), bus_address, a);
            @(negedge clk);
            bus_ready = 0; bus_read_data = 0;
            #1;
            check($sformatf("post_rst%0d imem_wait", k), {31'h0, imem_wait}, 32'h0);
            check($sformatf("post_rst%0d imem_data", k), imem_data, exp_q.pop_front());
        end
        check("post_rst overrun", {31'h0, overrun}, 32'h0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
